// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode.
// A circular FIFO of {inst, pc} entries. Fetch can push up to IB_WAYS
// instructions per cycle. Decode sees the IB_WAYS oldest entries and
// retires up to IB_WAYS of them from the head each cycle. A flush
// (mispredict) or reset empties the buffer on the next edge.
module inst_buffer #(
  parameter int IB_DEPTH = 8,
  parameter int IB_WAYS  = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [IB_WAYS-1:0]            if_valid,
  input  logic [IB_WAYS-1:0][31:0]      if_inst,
  input  logic [IB_WAYS-1:0][31:0]      if_pc,
  output logic                          ib_stall,
  output logic [IB_WAYS-1:0]            ib_valid,
  output logic [IB_WAYS-1:0][31:0]      ib_inst,
  output logic [IB_WAYS-1:0][31:0]      ib_pc,
  input  logic [1:0]                    id_accept,
  output logic [$clog2(IB_DEPTH):0]     ib_count
);

  localparam int PTR_W = $clog2(IB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Entry storage; deliberately not reset, pointers and count define validity
  logic [31:0] r_instMem [IB_DEPTH];
  logic [31:0] r_pcMem   [IB_DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W-1:0] w_freeCount;
  logic             w_enqEn;
  logic [CNT_W-1:0] w_enqCount;
  logic [IB_WAYS-1:0] w_slotWrite;
  logic [PTR_W-1:0] w_writeIdx [IB_WAYS];
  logic [CNT_W-1:0] w_availCount;
  logic [CNT_W-1:0] w_acceptReq;
  logic [CNT_W-1:0] w_deqCount;
  logic [PTR_W-1:0] w_readIdx [IB_WAYS];

  // Back-pressure depends only on the registered count, never on id_accept,
  // so fetch sees a stall that cannot be relieved by this cycle's dispatch.
  assign w_freeCount = CNT_W'(IB_DEPTH) - r_count;
  assign ib_stall    = (w_freeCount < CNT_W'(IB_WAYS));
  assign w_enqEn     = !ib_stall && !flush;
  assign ib_count    = r_count;

  // Enqueue: each valid fetch slot lands at tail plus the number of valid
  // slots before it, which keeps slot order even if a pattern had a gap.
  always_comb begin
    w_enqCount  = '0;
    w_slotWrite = '0;
    for (int i = 0; i < IB_WAYS; i++) begin
      w_writeIdx[i] = r_tail + PTR_W'(w_enqCount);
      if (w_enqEn && if_valid[i]) begin
        w_slotWrite[i] = 1'b1;
        w_enqCount     = w_enqCount + CNT_W'(1);
      end
    end
  end

  // Dequeue: decode may request more than is presented; clamp to the number
  // of valid output slots.
  always_comb begin
    w_availCount = (r_count > CNT_W'(IB_WAYS)) ? CNT_W'(IB_WAYS) : r_count;
    w_acceptReq  = CNT_W'(id_accept);
    w_deqCount   = (w_acceptReq < w_availCount) ? w_acceptReq : w_availCount;
  end

  // Output slots read straight from storage at head+i; empty slots show a NOP
  // at PC 0 so decode never sees stale entries.
  always_comb begin
    ib_valid = '0;
    ib_inst  = '0;
    ib_pc    = '0;
    for (int i = 0; i < IB_WAYS; i++) begin
      w_readIdx[i] = r_head + PTR_W'(i);
      ib_valid[i]  = (r_count > CNT_W'(i));
      if (ib_valid[i]) begin
        ib_inst[i] = r_instMem[w_readIdx[i]];
        ib_pc[i]   = r_pcMem[w_readIdx[i]];
      end else begin
        ib_inst[i] = NOP_INST;
        ib_pc[i]   = 32'h0;
      end
    end
  end

  // Write the accepted fetch slots into storage.
  always_ff @(posedge clock) begin
    for (int i = 0; i < IB_WAYS; i++) begin
      if (w_slotWrite[i]) begin
        r_instMem[w_writeIdx[i]] <= if_inst[i];
        r_pcMem[w_writeIdx[i]]   <= if_pc[i];
      end
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deqCount);
      r_tail  <= r_tail + PTR_W'(w_enqCount);
      r_count <= r_count + w_enqCount - w_deqCount;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Testbench for inst_buffer: directed fetch/dispatch vectors driven each
// cycle, with a scoreboard queue of expected PCs in program order and a
// negedge monitor that compares the presented slots and retires entries.
module tb_inst_buffer;

  localparam int DEPTH = 8;
  localparam int WAYS  = 3;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic              clock;
  logic              reset;
  logic              flush;
  logic [2:0]        if_valid;
  logic [2:0][31:0]  if_inst;
  logic [2:0][31:0]  if_pc;
  logic              ib_stall;
  logic [2:0]        ib_valid;
  logic [2:0][31:0]  ib_inst;
  logic [2:0][31:0]  ib_pc;
  logic [1:0]        id_accept;
  logic [3:0]        ib_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] sbQueue [$];
  int recvCount = 0;

  int modelCount = 0;
  bit modelKnown = 0;

  bit       expCheck = 0;
  bit       expClear = 0;
  int       expCount = 0;
  int       expDeq   = 0;
  bit       expStall = 0;
  logic [2:0] expValid = '0;

  inst_buffer #(.IB_DEPTH(DEPTH), .IB_WAYS(WAYS)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .ib_stall  (ib_stall),
    .ib_valid  (ib_valid),
    .ib_inst   (ib_inst),
    .ib_pc     (ib_pc),
    .id_accept (id_accept),
    .ib_count  (ib_count)
  );

  // Free-running clock, 10 time units per cycle
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction word tagged from its PC so a wrong pairing is visible
  function automatic logic [31:0] instFor(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  // One comparison: count it and report a mismatch
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict its effect, then let the edge pass
  task automatic applyStimulus(input logic rst, input logic fl, input logic [2:0] valid,
                               input logic [31:0] basePc, input logic [1:0] accept,
                               output int nEnq);
    int avail;
    int deq;
    int enq;
    reset     = rst;
    flush     = fl;
    if_valid  = valid;
    id_accept = accept;
    for (int i = 0; i < WAYS; i++) begin
      if_pc[i]   = basePc + 32'(4 * i);
      if_inst[i] = instFor(basePc + 32'(4 * i));
    end
    expCheck = modelKnown;
    expCount = modelCount;
    expStall = ((DEPTH - modelCount) < WAYS);
    for (int i = 0; i < WAYS; i++) expValid[i] = (modelCount > i);
    avail = (modelCount < WAYS) ? modelCount : WAYS;
    deq   = (int'(accept) < avail) ? int'(accept) : avail;
    enq   = 0;
    if (!expStall) for (int i = 0; i < WAYS; i++) if (valid[i]) enq++;
    nEnq = 0;
    if (rst || fl) begin
      expDeq     = 0;
      expClear   = 1;
      modelCount = 0;
      modelKnown = 1;
    end else begin
      expDeq   = deq;
      expClear = 0;
      for (int i = 0; i < enq; i++) sbQueue.push_back(basePc + 32'(4 * i));
      modelCount = modelCount + enq - deq;
      nEnq = enq;
    end
    @(posedge clock);
    #1;
  endtask

  // Directed check of occupancy, stall and valid mask against hand values
  task automatic checkOutput(input string name, input int cnt, input logic [2:0] valid, input bit stall);
    compare({name, "_count"}, 32'(ib_count), 32'(cnt));
    compare({name, "_valid"}, 32'(ib_valid), 32'(valid));
    compare({name, "_stall"}, 32'(ib_stall), 32'(stall));
    for (int i = 0; i < WAYS; i++) begin
      if (!valid[i]) begin
        compare($sformatf("%s_nop%0d", name, i), ib_inst[i], NOP_INST);
        compare($sformatf("%s_pc0_%0d", name, i), ib_pc[i], 32'h0);
      end
    end
  endtask

  // Directed check of one slot's PC and instruction
  task automatic checkPc(input string name, input int slot, input logic [31:0] pc);
    compare($sformatf("%s_slot%0d_pc", name, slot), ib_pc[slot], pc);
    compare($sformatf("%s_slot%0d_inst", name, slot), ib_inst[slot], instFor(pc));
  endtask

  // Monitor: compare presented slots with the scoreboard, then retire accepted ones
  always @(negedge clock) begin
    if (expCheck) begin
      compare("mon_count", 32'(ib_count), 32'(expCount));
      compare("mon_stall", 32'(ib_stall), 32'(expStall));
      compare("mon_valid", 32'(ib_valid), 32'(expValid));
      for (int i = 0; i < WAYS; i++) begin
        if (i < expCount) begin
          if (i < sbQueue.size()) begin
            compare($sformatf("mon_slot%0d_pc", i), ib_pc[i], sbQueue[i]);
            compare($sformatf("mon_slot%0d_inst", i), ib_inst[i], instFor(sbQueue[i]));
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL mon_underflow slot=%0d queued=%0d required>%0d", i, sbQueue.size(), i);
          end
        end else begin
          compare($sformatf("mon_slot%0d_nop", i), ib_inst[i], NOP_INST);
          compare($sformatf("mon_slot%0d_pc0", i), ib_pc[i], 32'h0);
        end
      end
      for (int i = 0; i < expDeq; i++) begin
        if (sbQueue.size() > 0) begin
          void'(sbQueue.pop_front());
          recvCount++;
        end
      end
    end
    if (expClear) sbQueue.delete();
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int n;
    int sent;
    int cycles;
    int recvStart;
    logic [2:0] v;
    reset = 1'b1; flush = 1'b0; if_valid = '0; id_accept = '0;
    if_inst = '0; if_pc = '0;

    applyStimulus(1, 0, 3'b000, 32'h0, 2'd0, n);
    applyStimulus(1, 0, 3'b000, 32'h0, 2'd0, n);
    checkOutput("reset", 0, 3'b000, 0);

    applyStimulus(0, 0, 3'b111, 32'h0, 2'd0, n);
    checkOutput("fill3", 3, 3'b111, 0);
    checkPc("fill3", 0, 32'h0);
    checkPc("fill3", 1, 32'h4);
    checkPc("fill3", 2, 32'h8);

    applyStimulus(0, 0, 3'b111, 32'hC, 2'd0, n);
    checkOutput("fill6", 6, 3'b111, 1);

    applyStimulus(0, 0, 3'b111, 32'h18, 2'd0, n);
    checkOutput("stallHold", 6, 3'b111, 1);
    checkPc("stallHold", 0, 32'h0);

    applyStimulus(0, 0, 3'b000, 32'h0, 2'd3, n);
    applyStimulus(0, 0, 3'b000, 32'h0, 2'd1, n);
    checkOutput("two", 2, 3'b011, 0);
    checkPc("two", 0, 32'h10);
    checkPc("two", 1, 32'h14);

    applyStimulus(0, 0, 3'b000, 32'h0, 2'd3, n);
    checkOutput("overAccept", 0, 3'b000, 0);

    applyStimulus(0, 0, 3'b111, 32'h100, 2'd0, n);
    applyStimulus(0, 0, 3'b001, 32'h10C, 2'd0, n);
    checkOutput("four", 4, 3'b111, 0);

    applyStimulus(0, 0, 3'b111, 32'h110, 2'd2, n);
    checkOutput("enqDeq", 5, 3'b111, 0);
    checkPc("enqDeq", 0, 32'h108);

    applyStimulus(0, 1, 3'b111, 32'h200, 2'd1, n);
    checkOutput("flush", 0, 3'b000, 0);

    // Stream 20 instructions through with random dispatch width
    sent = 0;
    cycles = 0;
    recvStart = recvCount;
    while ((sent < 20 || modelCount > 0) && cycles < 300) begin
      if (20 - sent >= 3)      v = 3'b111;
      else if (20 - sent == 2) v = 3'b011;
      else if (20 - sent == 1) v = 3'b001;
      else                     v = 3'b000;
      applyStimulus(0, 0, v, 32'h1000 + 32'(4 * sent), 2'($urandom_range(0, 3)), n);
      sent += n;
      cycles++;
    end
    compare("stream_budget", 32'(cycles < 300), 32'd1);
    compare("stream_received", 32'(recvCount - recvStart), 32'd20);
    compare("stream_leftover", 32'(sbQueue.size()), 32'd0);
    checkOutput("drained", 0, 3'b000, 0);

    applyStimulus(0, 0, 3'b111, 32'h300, 2'd0, n);
    checkOutput("preReset", 3, 3'b111, 0);
    applyStimulus(1, 0, 3'b111, 32'h400, 2'd2, n);
    checkOutput("midReset", 0, 3'b000, 0);
    applyStimulus(0, 0, 3'b000, 32'h0, 2'd0, n);
    checkOutput("postReset", 0, 3'b000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
